// File: rtl/ex_m_pipe.sv
// EX->M pipeline register with valid/ready handshake; one-cycle latency, full throughput.
// Define EX_M_PIPE_SKID_EN for a registered-ready two-entry (head + skid) buffer; default is a single entry.
module ex_m_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_E,
    output logic              ready_E,
    input  logic              RegW_enable_E,
    input  logic              Mem_Write_E,
    input  logic              Mem_Read_E,
    input  logic              Result_src_E,
    input  logic [DATA_W-1:0] ALU_result_E,
    input  logic [DATA_W-1:0] Write_Data_E,
    input  logic [ADDR_W-1:0] RDadd_E,
    output logic              valid_M,
    input  logic              ready_M,
    output logic              RegW_enable_M,
    output logic              Mem_Write_M,
    output logic              Mem_Read_M,
    output logic              Result_src_M,
    output logic [DATA_W-1:0] ALU_result_M,
    output logic [DATA_W-1:0] Write_Data_M,
    output logic [ADDR_W-1:0] RDadd_M,
    output logic [1:0]        occ_M
);

    typedef struct packed {
        logic              regw;
        logic              mwr;
        logic              mrd;
        logic              rsrc;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdat;
        logic [ADDR_W-1:0] rd;
    } ent_t;

    ent_t       in_ent;
    ent_t       head_q, head_d;
    logic [1:0] occ_q, occ_d;
    logic       accept;
    logic       emit;

    assign in_ent = '{regw: RegW_enable_E, mwr: Mem_Write_E, mrd: Mem_Read_E,
                      rsrc: Result_src_E, alu: ALU_result_E, wdat: Write_Data_E,
                      rd: RDadd_E};

    assign valid_M = (occ_q != 2'd0);
    assign emit    = valid_M & ready_M;
    assign accept  = valid_E & ready_E & ~flush;

`ifdef EX_M_PIPE_SKID_EN
    ent_t skid_q, skid_d;
    logic ready_q, ready_d;

    assign ready_E = ready_q;

    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        occ_d   = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else if (emit && accept) begin
            // ready_E is low at occ 2, so this is always the one-entry replace case
            head_d = in_ent;
        end else if (emit) begin
            if (occ_q == 2'd2) begin
                head_d = skid_q;
                occ_d  = 2'd1;
            end else begin
                occ_d  = 2'd0;
            end
        end else if (accept) begin
            if (occ_q == 2'd0) begin
                head_d = in_ent;
                occ_d  = 2'd1;
            end else begin
                skid_d = in_ent;
                occ_d  = 2'd2;
            end
        end
        ready_d = (occ_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            skid_q  <= '0;
            occ_q   <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            occ_q   <= occ_d;
            ready_q <= ready_d;
        end
    end
`else
    assign ready_E = ~valid_M | ready_M;

    always_comb begin
        head_d = head_q;
        occ_d  = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else if (accept) begin
            head_d = in_ent;
            occ_d  = 2'd1;
        end else if (emit) begin
            occ_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            occ_q  <= occ_d;
        end
    end
`endif

    // Data fields keep the last head value during bubbles; only side-effecting controls are gated.
    assign RegW_enable_M = head_q.regw & valid_M;
    assign Mem_Write_M   = head_q.mwr & valid_M;
    assign Mem_Read_M    = head_q.mrd & valid_M;
    assign Result_src_M  = head_q.rsrc;
    assign ALU_result_M  = head_q.alu;
    assign Write_Data_M  = head_q.wdat;
    assign RDadd_M       = head_q.rd;
    assign occ_M         = occ_q;

endmodule

// File: doc/ex_m_pipe.md
EX_M_PIPE -- requirements
Module: ex_m_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of ALU result and store data.
REQ-002 SHALL provide parameter ADDR_W, default 5, width of destination register address.
REQ-003 SHALL have ports (clock and reset first; one clock; reset synchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held and incoming entries
- valid_E  in  1  EX-side entry present
- ready_E  out  1  stage can accept an entry
- RegW_enable_E, Mem_Write_E, Mem_Read_E, Result_src_E  in  1 each  EX control bits
- ALU_result_E, Write_Data_E  in  DATA_W each  EX data
- RDadd_E  in  ADDR_W  destination register
- valid_M  out  1  M-side entry present
- ready_M  in  1  M stage consumes entry
- RegW_enable_M, Mem_Write_M, Mem_Read_M, Result_src_M  out  1 each  gated control
- ALU_result_M, Write_Data_M  out  DATA_W each
- RDadd_M  out  ADDR_W
- occ_M  out  2  entries held (0..2)

Function
REQ-004 Accept SHALL occur on a rising edge with valid_E=1 and ready_E=1; emit SHALL occur with valid_M=1 and ready_M=1.
REQ-005 Latency SHALL be exactly 1 cycle from accept into an empty stage to valid_M=1.
REQ-006 Entries SHALL leave in acceptance order; none duplicated or lost except by flush/rst.
REQ-007 Output fields SHALL come from the head entry; when valid_M=0, RegW_enable_M, Mem_Write_M and Mem_Read_M SHALL read 0 (bubble), and the data fields SHALL hold their last value.
REQ-008 Head entry and all outputs SHALL stay stable while valid_M=1 and ready_M=0.
REQ-009 Simultaneous accept and emit on a one-entry-full stage SHALL replace the head with no bubble cycle (full throughput).
REQ-010 flush=1 SHALL, at that edge, clear every held entry (occ_M=0, valid_M=0) and drop any entry presented that cycle; flush SHALL take priority over accept and emit.
REQ-011 occ_M SHALL equal the number of valid held entries after each edge.
REQ-012 Input widths SHALL pass unmodified; no truncation or extension.

Reset
REQ-013 rst=1 at a rising edge SHALL clear all entries; valid_M=0, occ_M=0, every _M output 0.
REQ-014 rst SHALL take priority over flush, accept and emit; a transfer in progress is discarded.
REQ-015 ready_E SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-016 Macro EX_M_PIPE_SKID_EN SHALL select the buffering mode.
REQ-017 With EX_M_PIPE_SKID_EN defined: two-entry buffer (head + skid); ready_E SHALL be a register output equal to ~(occ_M==2); an entry accepted while the head is stalled SHALL go to skid; when the head is emitted, skid SHALL move to head the same edge.
REQ-018 Without EX_M_PIPE_SKID_EN: single entry; ready_E SHALL be combinational ~valid_M | ready_M; occ_M SHALL never exceed 1.

Verification
REQ-019 Stream: ready_M=1, valid_E=1 for 4 cycles, ALU_result_E=0x10,0x20,0x30,0x40 -> valid_M 1 cycle later, ALU_result_M 0x10..0x40 on consecutive cycles, no bubble.
REQ-020 Backpressure (SKID_EN): ready_M=0, push 0xA,0xB -> occ_M=2, ready_E=0, ALU_result_M=0xA held; ready_M=1 -> 0xA then 0xB emitted, ready_E returns 1.
REQ-021 Backpressure (no SKID_EN): ready_M=0, valid_M=1 -> ready_E=0 same cycle; ready_M=1 -> ready_E=1 combinationally, replace without bubble.
REQ-022 Bubble gating: valid_E=0 with RegW_enable_E=1, Mem_Write_E=1 -> valid_M=0, RegW_enable_M=0, Mem_Write_M=0.
REQ-023 Flush: occ_M=2 and valid_E=1 with flush=1 -> next cycle occ_M=0, valid_M=0, incoming entry never appears.
REQ-024 Reset mid-stall: occ_M=1, ready_M=0, rst=1 one cycle -> all _M outputs 0, valid_M=0; next cycle ready_E=1.
